// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, round functions and FSM state type used by the
// round core, the K generator and any upstream padder.
package sha256_pkg;

  localparam int NUM_ROUNDS = 64;
  localparam int NUM_WORDS  = 16;

  localparam logic [31:0] H0_INIT = 32'h6a09e667;
  localparam logic [31:0] H1_INIT = 32'hbb67ae85;
  localparam logic [31:0] H2_INIT = 32'h3c6ef372;
  localparam logic [31:0] H3_INIT = 32'ha54ff53a;
  localparam logic [31:0] H4_INIT = 32'h510e527f;
  localparam logic [31:0] H5_INIT = 32'h9b05688c;
  localparam logic [31:0] H6_INIT = 32'h1f83d9ab;
  localparam logic [31:0] H7_INIT = 32'h5be0cd19;

  typedef enum logic [1:0] {LOAD, ROUND, FINAL} state_t;

  function automatic logic [31:0] iv_word(input int i);
    case (i)
      0:       return H0_INIT;
      1:       return H1_INIT;
      2:       return H2_INIT;
      3:       return H3_INIT;
      4:       return H4_INIT;
      5:       return H5_INIT;
      6:       return H6_INIT;
      default: return H7_INIT;
    endcase
  endfunction

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                    input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha256_msg_sched.sv
// 16-word sliding message window: loads shift words in at the tail, rounds
// shift the expanded schedule word in; w_cur is always W[r] of the current round.
module sha256_msg_sched
  import sha256_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_word,
  input  logic        shift,
  output logic [31:0] w_cur
);

  logic [31:0] w_q [NUM_WORDS];
  logic [31:0] w_d [NUM_WORDS];
  logic [31:0] tail;
  logic        adv;

  assign adv   = load | shift;
  assign tail  = load ? load_word
                      : small_sigma1(w_q[14]) + w_q[9] + small_sigma0(w_q[1]) + w_q[0];
  assign w_cur = w_q[0];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_WORDS - 1; gi++) begin : g_win
      assign w_d[gi] = adv ? w_q[gi + 1] : w_q[gi];
    end
  endgenerate
  assign w_d[NUM_WORDS-1] = adv ? tail : w_q[NUM_WORDS-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_WORDS; i++) w_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_WORDS; i++) w_q[i] <= w_d[i];
    end
  end

endmodule

// File: rtl/sha256_round_core.sv
// SHA-256 compression engine: streams in one block, runs 64 rounds against the
// external K generator, then folds the result into the chaining value.
module sha256_round_core
  import sha256_pkg::*;
#(
  parameter int ROUNDS = NUM_ROUNDS,
  parameter int WORDS  = NUM_WORDS
)
(
  input  logic         clk,
  input  logic         rst,
  input  logic         msg_valid,
  output logic         msg_ready,
  input  logic [31:0]  msg_word,
  input  logic         msg_first,
  output logic         k_en,
  input  logic [31:0]  k_in,
  output logic [255:0] digest,
  output logic         digest_valid,
  output logic         busy
);

  localparam int CW = $clog2(WORDS);
  localparam int RW = $clog2(ROUNDS);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] round_q, round_d;
  logic [31:0]   wv_q   [8];
  logic [31:0]   wv_d   [8];
  logic [31:0]   hash_q [8];
  logic [31:0]   hash_d [8];
  logic [31:0]   dig_q  [8];
  logic [31:0]   dig_d  [8];
  logic          dv_q, dv_d;
  logic [31:0]   w_cur, t1, t2;
  logic          xfer;

  assign msg_ready    = (state_q == LOAD);
  assign xfer         = msg_valid && msg_ready;
  assign k_en         = (state_q == ROUND);
  assign busy         = (state_q != LOAD);
  assign digest_valid = dv_q;

  sha256_msg_sched u_sched (
    .clk       (clk),
    .rst       (rst),
    .load      (xfer),
    .load_word (msg_word),
    .shift     (k_en),
    .w_cur     (w_cur)
  );

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_dig
      assign digest[255-32*gi -: 32] = dig_q[gi];
    end
  endgenerate

  // wv index 0..7 maps to working variables a..h
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    round_d = round_q;
    wv_d    = wv_q;
    hash_d  = hash_q;
    dig_d   = dig_q;
    dv_d    = dv_q;
    t1 = wv_q[7] + big_sigma1(wv_q[4]) + ch(wv_q[4], wv_q[5], wv_q[6]) + k_in + w_cur;
    t2 = big_sigma0(wv_q[0]) + maj(wv_q[0], wv_q[1], wv_q[2]);

    case (state_q)
      LOAD: begin
        if (xfer) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == '0) begin
            dv_d = 1'b0;
            if (msg_first) begin
              for (int i = 0; i < 8; i++) hash_d[i] = iv_word(i);
            end
          end
          if (cnt_q == CW'(WORDS - 1)) begin
            wv_d    = hash_q;
            cnt_d   = '0;
            round_d = '0;
            state_d = ROUND;
          end
        end
      end
      ROUND: begin
        wv_d[7] = wv_q[6];
        wv_d[6] = wv_q[5];
        wv_d[5] = wv_q[4];
        wv_d[4] = wv_q[3] + t1;
        wv_d[3] = wv_q[2];
        wv_d[2] = wv_q[1];
        wv_d[1] = wv_q[0];
        wv_d[0] = t1 + t2;
        round_d = round_q + 1'b1;
        if (round_q == RW'(ROUNDS - 1)) state_d = FINAL;
      end
      FINAL: begin
        for (int i = 0; i < 8; i++) begin
          hash_d[i] = hash_q[i] + wv_q[i];
          dig_d[i]  = hash_q[i] + wv_q[i];
        end
        dv_d    = 1'b1;
        state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      round_q <= '0;
      dv_q    <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        wv_q[i]   <= '0;
        hash_q[i] <= iv_word(i);
        dig_q[i]  <= iv_word(i);
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      round_q <= round_d;
      dv_q    <= dv_d;
      for (int i = 0; i < 8; i++) begin
        wv_q[i]   <= wv_d[i];
        hash_q[i] <= hash_d[i];
        dig_q[i]  <= dig_d[i];
      end
    end
  end

endmodule

// File: tb/tb_sha256_round_core.sv
// Self-checking bench for sha256_round_core: known FIPS vectors plus random
// blocks checked against a straightforward SHA-256 compression model.
module tb_sha256_round_core;

  localparam logic [31:0] K_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC_DIG   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY_DIG = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] TWO_DIG   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         msg_valid = 1'b0;
  logic         msg_ready;
  logic [31:0]  msg_word = '0;
  logic         msg_first = 1'b0;
  logic         k_en;
  logic [31:0]  k_in;
  logic [255:0] digest;
  logic         digest_valid;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [511:0] abc_blk, empty_blk, two_blk1, two_blk2;

  sha256_round_core dut (
    .clk          (clk),
    .rst          (rst),
    .msg_valid    (msg_valid),
    .msg_ready    (msg_ready),
    .msg_word     (msg_word),
    .msg_first    (msg_first),
    .k_en         (k_en),
    .k_in         (k_in),
    .digest       (digest),
    .digest_valid (digest_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Stand-in for the K generator: round index advances on k_en, clears on reset.
  logic [5:0] k_idx;
  always @(posedge clk) begin
    if (rst) k_idx <= 6'd0;
    else if (k_en) k_idx <= k_idx + 6'd1;
  end
  assign k_in = K_TAB[k_idx];

  function automatic logic [31:0] f_rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Plain FIPS 180-4 compression with the fully expanded 64-entry schedule.
  function automatic logic [255:0] ref_compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] s0, s1, t1, t2;
    logic [255:0] hout;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = f_rotr(w[i-15], 7) ^ f_rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = f_rotr(w[i-2], 17) ^ f_rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = s1 + w[i-7] + s0 + w[i-16];
    end
    for (int i = 0; i < 8; i++) v[i] = hin[255-32*i -: 32];
    for (int r = 0; r < 64; r++) begin
      t1 = v[7] + (f_rotr(v[4], 6) ^ f_rotr(v[4], 11) ^ f_rotr(v[4], 25))
           + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K_TAB[r] + w[r];
      t2 = (f_rotr(v[0], 2) ^ f_rotr(v[0], 13) ^ f_rotr(v[0], 22))
           + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) hout[255-32*i -: 32] = hin[255-32*i -: 32] + v[i];
    return hout;
  endfunction

  task automatic load_words(input logic [511:0] blk, input bit first, input bit gaps);
    int idle;
    for (int i = 0; i < 16; i++) begin
      idle = 0;
      if (gaps && $urandom_range(0, 2) == 0) idle = $urandom_range(1, 3);
      repeat (idle) begin
        msg_valid = 1'b0;
        msg_word  = $urandom;
        msg_first = 1'($urandom);
        @(posedge clk); #1;
      end
      msg_valid = 1'b1;
      msg_word  = blk[511-32*i -: 32];
      msg_first = (i == 0) ? first : (gaps ? 1'($urandom) : 1'b0);
      @(posedge clk); #1;
      if (i == 0) begin
        n_tests++;
        if (digest_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL dv_clear_after_w0: got %b expected 0", digest_valid);
        end
      end
    end
    msg_valid = 1'b0;
    msg_first = 1'b0;
  endtask

  // Streams one block and watches cycles t+1..t+70 after the 16th word.
  task automatic run_block(input logic [511:0] blk, input bit first, input bit gaps,
                           input bit hold, input logic [255:0] exp, input string name);
    int kc, kout, busy_bad, ready_bad, dv_n;
    logic [31:0] k_first, k_last;
    kc = 0; kout = 0; busy_bad = 0; ready_bad = 0; dv_n = 0;
    k_first = '0; k_last = '0;
    load_words(blk, first, gaps);
    if (hold) begin
      msg_valid = 1'b1;
      msg_word  = $urandom;
    end
    for (int n = 1; n <= 70; n++) begin
      if (n <= 64) begin
        if (k_en === 1'b1) kc++;
        if (n == 1)  k_first = k_in;
        if (n == 64) k_last  = k_in;
      end else if (k_en !== 1'b0) kout++;
      if (busy !== 1'(n <= 65)) busy_bad++;
      if (msg_ready !== 1'(n >= 66)) ready_bad++;
      if (digest_valid === 1'b1 && dv_n == 0) dv_n = n;
      if (n == 66) begin
        n_tests++;
        if (digest !== exp) begin
          n_fail++;
          $display("FAIL %s digest: got %h expected %h", name, digest, exp);
        end
      end
      if (hold && n < 65) msg_word = $urandom;
      if (n == 65) msg_valid = 1'b0;
      if (n < 70) begin
        @(posedge clk); #1;
      end
    end
    n_tests++;
    if (kc != 64 || kout != 0) begin
      n_fail++;
      $display("FAIL %s k_en_pulses: got %0d in-window %0d outside, expected 64 and 0", name, kc, kout);
    end
    n_tests++;
    if (k_first !== 32'h428a2f98 || k_last !== 32'hc67178f2) begin
      n_fail++;
      $display("FAIL %s k_in_ends: got %h/%h expected 428a2f98/c67178f2", name, k_first, k_last);
    end
    n_tests++;
    if (busy_bad != 0 || ready_bad != 0) begin
      n_fail++;
      $display("FAIL %s busy_ready: got %0d/%0d bad cycles expected 0/0", name, busy_bad, ready_bad);
    end
    n_tests++;
    if (dv_n != 66) begin
      n_fail++;
      $display("FAIL %s dv_latency: got t+%0d expected t+66", name, dv_n);
    end
    n_tests++;
    if (digest_valid !== 1'b1 || digest !== exp) begin
      n_fail++;
      $display("FAIL %s digest_hold: got %b/%h expected 1/%h", name, digest_valid, digest, exp);
    end
    $display("[TB] block %s done, digest %h", name, digest);
  endtask

  task automatic check_idle_after_reset(input string name);
    n_tests++;
    if (digest_valid !== 1'b0 || busy !== 1'b0 || k_en !== 1'b0 || msg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ctrl: got dv=%b busy=%b k_en=%b ready=%b expected 0 0 0 1",
               name, digest_valid, busy, k_en, msg_ready);
    end
    n_tests++;
    if (digest !== IV) begin
      n_fail++;
      $display("FAIL %s digest: got %h expected %h", name, digest, IV);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    msg_valid = 1'b1;
    msg_word = $urandom;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check_idle_after_reset("reset");
    rst = 1'b0;
    msg_valid = 1'b0;
    $display("[TB] reset checked");
  endtask

  task automatic test_abc();
    run_block(abc_blk, 1'b1, 1'b0, 1'b0, ABC_DIG, "abc");
  endtask

  task automatic test_empty();
    run_block(empty_blk, 1'b1, 1'b0, 1'b0, EMPTY_DIG, "empty");
  endtask

  task automatic test_back_to_back();
    run_block(two_blk1, 1'b1, 1'b0, 1'b0, ref_compress(IV, two_blk1), "two_blk1");
    run_block(two_blk2, 1'b0, 1'b0, 1'b0, TWO_DIG, "two_blk2");
    run_block(abc_blk, 1'b1, 1'b0, 1'b0, ABC_DIG, "abc_after_two");
  endtask

  task automatic test_gaps_hold();
    run_block(abc_blk, 1'b1, 1'b1, 1'b1, ABC_DIG, "abc_gaps_hold");
  endtask

  task automatic test_random();
    logic [511:0] b1, b2;
    logic [255:0] e1, e2;
    for (int it = 0; it < 3; it++) begin
      for (int i = 0; i < 16; i++) begin
        b1[511-32*i -: 32] = $urandom;
        b2[511-32*i -: 32] = $urandom;
      end
      e1 = ref_compress(IV, b1);
      e2 = ref_compress(e1, b2);
      run_block(b1, 1'b1, 1'b1, it == 1, e1, "rand_blk1");
      run_block(b2, 1'b0, 1'b1, it == 2, e2, "rand_blk2");
    end
  endtask

  task automatic test_reset_mid_round();
    load_words(abc_blk, 1'b1, 1'b0);
    repeat (30) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    msg_valid = 1'b1;
    msg_word = $urandom;
    @(posedge clk); #1;
    rst = 1'b0;
    msg_valid = 1'b0;
    check_idle_after_reset("reset_mid_round");
    run_block(abc_blk, 1'b1, 1'b0, 1'b0, ABC_DIG, "abc_after_round_reset");
  endtask

  task automatic test_reset_mid_load();
    for (int i = 0; i < 7; i++) begin
      msg_valid = 1'b1;
      msg_word  = $urandom;
      msg_first = (i == 0);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    msg_valid = 1'b0;
    msg_first = 1'b0;
    check_idle_after_reset("reset_mid_load");
    // msg_first=0: only a reset-restored IV can give the abc digest here
    run_block(abc_blk, 1'b0, 1'b0, 1'b0, ABC_DIG, "abc_after_load_reset");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    abc_blk   = {32'h61626380, 448'h0, 32'h00000018};
    empty_blk = {32'h80000000, 480'h0};
    two_blk1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                 32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    two_blk2  = {480'h0, 32'h000001c0};
    #1;
    test_reset();
    test_abc();
    test_empty();
    test_back_to_back();
    test_gaps_hold();
    test_random();
    test_reset_mid_round();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
